// File: rtl/alu_issue_if.sv
// Handshake and operand bundle between ID, the ALU issue stage and the ALU.
// The master drives the instruction side and consumes the result side; the slave is the stage.
// Parameterised on DATA_MSB so operand buses track the stage width.
interface alu_issue_if #(
  parameter int DATA_MSB = 63
);
  // ID -> stage
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          alu_op;
  logic [2:0]          funct3;
  logic                funct7_b5;
  logic                alu_src;
  logic [DATA_MSB:0]   rs1_data;
  logic [DATA_MSB:0]   rs2_data;
  logic [DATA_MSB:0]   imm;
  logic                flush;

  // stage -> ALU / EX
  logic                out_valid;
  logic                out_ready;
  logic [DATA_MSB:0]   data1;
  logic [DATA_MSB:0]   data2;
  logic [3:0]          alu_select;
  logic                illegal;

  modport master (
    output in_valid, alu_op, funct3, funct7_b5, alu_src,
           rs1_data, rs2_data, imm, flush, out_ready,
    input  in_ready, out_valid, data1, data2, alu_select, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct3, funct7_b5, alu_src,
           rs1_data, rs2_data, imm, flush, out_ready,
    output in_ready, out_valid, data1, data2, alu_select, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Execute-issue stage: decodes ALUOp/funct into the ALU select code and muxes operand 2.
// Latency: one cycle from accept to out_valid; full throughput when out_ready stays high.
// Backpressure: holds outputs bit-stable while out_valid && !out_ready; flush wins over everything.
// Optional: define ALU_ISSUE_ERR_CNT_EN to add a saturating err_count of accepted illegal encodings.
module alu_issue_stage #(
  parameter int DATA_MSB = 63
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
`ifdef ALU_ISSUE_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  logic              out_valid_q;
  logic [DATA_MSB:0] data1_q;
  logic [DATA_MSB:0] data2_q;
  logic [3:0]        alu_select_q;
  logic              illegal_q;

  logic              in_ready_c;
  logic              accept;
  logic [3:0]        dec_sel;
  logic              dec_illegal;
  logic [DATA_MSB:0] op2_sel;

  // Ready depends only on the held slot and flush, never on in_valid.
  assign in_ready_c = !bus.flush && (!out_valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;
  assign op2_sel    = bus.alu_src ? bus.imm : bus.rs2_data;

  // Map ALUOp plus funct fields onto the ALU select code; unknown R-type encodings fall back to add.
  always_comb begin
    dec_sel     = 4'b0010;
    dec_illegal = 1'b0;
    case (bus.alu_op)
      2'b00: dec_sel = 4'b0010;
      2'b01: dec_sel = 4'b0110;
      2'b11: dec_sel = 4'b0111;
      default: begin
        case ({bus.funct3, bus.funct7_b5})
          4'b000_0: dec_sel = 4'b0010;
          4'b000_1: dec_sel = 4'b0110;
          4'b111_0: dec_sel = 4'b0000;
          4'b110_0: dec_sel = 4'b0001;
          4'b100_1: dec_sel = 4'b1100;
          default: begin
            dec_sel     = 4'b0010;
            dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Valid/illegal flags: flush kills, accept loads, a lone drain empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      illegal_q   <= dec_illegal;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end
  end

  // Operand and select registers only change on accept; they hold through drain, stall and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data1_q      <= '0;
      data2_q      <= '0;
      alu_select_q <= 4'b0000;
    end else if (accept) begin
      data1_q      <= bus.rs1_data;
      data2_q      <= op2_sel;
      alu_select_q <= dec_sel;
    end
  end

`ifdef ALU_ISSUE_ERR_CNT_EN
  // Count accepted illegal encodings, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 16'h0000;
    end else if (accept && dec_illegal && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'h0001;
    end
  end
`endif

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.data1      = data1_q;
  assign bus.data2      = data2_q;
  assign bus.alu_select = alu_select_q;
  assign bus.illegal    = illegal_q;

endmodule
